// File: rtl/mor1kx_dbg_insn_seq_pkg.sv
// Shared types and ORBIS32 encoders for the debug instruction sequencer.
// Opcodes mirror the decode side so injected words decode to the intended ops.
package mor1kx_dbg_insn_seq_pkg;

  typedef enum logic [5:0] {
    OPCODE_MOVHI = 6'h06,
    OPCODE_LWZ   = 6'h21,
    OPCODE_ORI   = 6'h2A,
    OPCODE_MFSPR = 6'h2D,
    OPCODE_MTSPR = 6'h30,
    OPCODE_SW    = 6'h35
  } opcode_t;

  typedef enum logic [1:0] {
    DBG_RD_SPR = 2'd0,
    DBG_WR_SPR = 2'd1,
    DBG_RD_MEM = 2'd2,
    DBG_WR_MEM = 2'd3
  } dbg_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT    = 2'd1,
    WAIT_WB = 2'd2,
    RESP    = 2'd3
  } dbg_seq_state_t;

  localparam int STEP_W = 3;

  function automatic logic [31:0] enc_movhi(input logic [4:0] rd, input logic [15:0] k);
    return {OPCODE_MOVHI, rd, 5'b0, k};
  endfunction

  function automatic logic [31:0] enc_ori(input logic [4:0] rd, input logic [4:0] ra,
                                          input logic [15:0] k);
    return {OPCODE_ORI, rd, ra, k};
  endfunction

  function automatic logic [31:0] enc_mfspr(input logic [4:0] rd, input logic [4:0] ra);
    return {OPCODE_MFSPR, rd, ra, 16'h0};
  endfunction

  function automatic logic [31:0] enc_mtspr(input logic [4:0] ra, input logic [4:0] rb);
    return {OPCODE_MTSPR, 5'h0, ra, rb, 11'h0};
  endfunction

  function automatic logic [31:0] enc_lwz(input logic [4:0] rd, input logic [4:0] ra);
    return {OPCODE_LWZ, rd, ra, 16'h0};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] ra, input logic [4:0] rb);
    return {OPCODE_SW, 5'h0, ra, rb, 11'h0};
  endfunction

endpackage

// File: rtl/mor1kx_dbg_insn_seq_encode.sv
// Combinational step -> instruction word table for debug sequences.
// Writes load data into S, then the address into A; reads only need A.
module mor1kx_insn_encode
  import mor1kx_dbg_insn_seq_pkg::*;
(
  input  dbg_cmd_t          op_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic [4:0]        scratchData_i,
  input  logic [4:0]        scratchAddr_i,
  output logic [31:0]       insn_o,
  output logic              last_o
);

  logic isWrite;
  logic isMem;

  assign isWrite = (op_i == DBG_WR_SPR) || (op_i == DBG_WR_MEM);
  assign isMem   = (op_i == DBG_RD_MEM) || (op_i == DBG_WR_MEM);

  always_comb begin
    insn_o = '0;
    last_o = 1'b0;
    if (isWrite) begin
      case (step_i)
        3'd0: insn_o = enc_movhi(scratchData_i, data_i[31:16]);
        3'd1: insn_o = enc_ori(scratchData_i, scratchData_i, data_i[15:0]);
        3'd2: insn_o = enc_movhi(scratchAddr_i, addr_i[31:16]);
        3'd3: insn_o = enc_ori(scratchAddr_i, scratchAddr_i, addr_i[15:0]);
        3'd4: begin
          last_o = 1'b1;
          insn_o = isMem ? enc_sw(scratchAddr_i, scratchData_i)
                         : enc_mtspr(scratchAddr_i, scratchData_i);
        end
        default: insn_o = '0;
      endcase
    end else begin
      case (step_i)
        3'd0: insn_o = enc_movhi(scratchAddr_i, addr_i[31:16]);
        3'd1: insn_o = enc_ori(scratchAddr_i, scratchAddr_i, addr_i[15:0]);
        3'd2: begin
          last_o = 1'b1;
          insn_o = isMem ? enc_lwz(scratchData_i, scratchAddr_i)
                         : enc_mfspr(scratchData_i, scratchAddr_i);
        end
        default: insn_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/mor1kx_dbg_insn_seq.sv
// Debug instruction sequencer: turns SPR/memory commands into injected ORBIS32
// words and returns read results captured from the scratch GPR writeback.
module mor1kx_dbg_insn_seq
  import mor1kx_dbg_insn_seq_pkg::*;
#(
  parameter logic [4:0]  SCRATCH_DATA_REG = 5'd3,
  parameter logic [4:0]  SCRATCH_ADDR_REG = 5'd4,
  parameter int unsigned WB_TIMEOUT       = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  output logic        insn_valid_o,
  input  logic        insn_ready_i,
  output logic [31:0] insn_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o
);

  localparam int CNT_W = (WB_TIMEOUT > 2) ? $clog2(WB_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WB_TIMEOUT - 1);

  dbg_seq_state_t    state_q, state_d;
  dbg_cmd_t          op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmdReady_q, cmdReady_d;
  logic              insnValid_q, insnValid_d;
  logic [31:0]       insn_q, insn_d;
  logic              last_q, last_d;
  logic              rspValid_q, rspValid_d;
  logic [31:0]       rspData_q, rspData_d;
  logic              rspErr_q, rspErr_d;

  logic [31:0]       encWord;
  logic              encLast;

  // Encoder looks at next-state fields so the word is registered alongside its step.
  mor1kx_insn_encode u_encode (
    .op_i          (op_d),
    .step_i        (step_d),
    .addr_i        (addr_d),
    .data_i        (data_d),
    .scratchData_i (SCRATCH_DATA_REG),
    .scratchAddr_i (SCRATCH_ADDR_REG),
    .insn_o        (encWord),
    .last_o        (encLast)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    cmdReady_d  = cmdReady_q;
    insnValid_d = insnValid_q;
    insn_d      = insn_q;
    last_d      = last_q;
    rspValid_d  = rspValid_q;
    rspData_d   = rspData_q;
    rspErr_d    = rspErr_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d     = EMIT;
          op_d        = dbg_cmd_t'(cmd_op_i);
          addr_d      = cmd_addr_i;
          data_d      = cmd_data_i;
          step_d      = '0;
          cmdReady_d  = 1'b0;
          insnValid_d = 1'b1;
          insn_d      = encWord;
          last_d      = encLast;
        end
      end
      EMIT: begin
        if (insn_ready_i) begin
          if (last_q) begin
            insnValid_d = 1'b0;
            insn_d      = '0;
            last_d      = 1'b0;
            if (op_q == DBG_WR_SPR || op_q == DBG_WR_MEM) begin
              state_d    = RESP;
              rspValid_d = 1'b1;
              rspData_d  = '0;
              rspErr_d   = 1'b0;
            end else begin
              state_d = WAIT_WB;
              cnt_d   = '0;
            end
          end else begin
            step_d = step_q + 3'd1;
            insn_d = encWord;
            last_d = encLast;
          end
        end
      end
      WAIT_WB: begin
        // A matching writeback wins even on the final timeout cycle.
        if (wb_valid_i && wb_rd_i == SCRATCH_DATA_REG) begin
          state_d    = RESP;
          rspValid_d = 1'b1;
          rspData_d  = wb_data_i;
          rspErr_d   = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d    = RESP;
          rspValid_d = 1'b1;
          rspData_d  = '0;
          rspErr_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d    = IDLE;
          rspValid_d = 1'b0;
          rspData_d  = '0;
          rspErr_d   = 1'b0;
          cmdReady_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= DBG_RD_SPR;
      addr_q      <= '0;
      data_q      <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      cmdReady_q  <= 1'b1;
      insnValid_q <= 1'b0;
      insn_q      <= '0;
      last_q      <= 1'b0;
      rspValid_q  <= 1'b0;
      rspData_q   <= '0;
      rspErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      cmdReady_q  <= cmdReady_d;
      insnValid_q <= insnValid_d;
      insn_q      <= insn_d;
      last_q      <= last_d;
      rspValid_q  <= rspValid_d;
      rspData_q   <= rspData_d;
      rspErr_q    <= rspErr_d;
    end
  end

  assign cmd_ready_o  = cmdReady_q;
  assign insn_valid_o = insnValid_q;
  assign insn_o       = insn_q;
  assign rsp_valid_o  = rspValid_q;
  assign rsp_data_o   = rspData_q;
  assign rsp_err_o    = rspErr_q;

endmodule

// File: tb/tb_mor1kx_dbg_insn_seq.sv
// Directed bench for the debug instruction sequencer: a vector table of full
// transactions plus hand-written stall, timeout, back-pressure and reset cases.
module tb_mor1kx_dbg_insn_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        insn_valid_o;
  logic        insn_ready_i;
  logic [31:0] insn_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;

  int vecCount  = 0;
  int failCount = 0;

  typedef struct packed {
    logic [1:0]       op;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [2:0]       nWords;
    logic [4:0][31:0] words;
    logic [31:0]      wbData;
    logic [31:0]      expData;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  mor1kx_dbg_insn_seq #(
    .SCRATCH_DATA_REG (5'd3),
    .SCRATCH_ADDR_REG (5'd4),
    .WB_TIMEOUT       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .insn_valid_o (insn_valid_o),
    .insn_ready_i (insn_ready_i),
    .insn_o       (insn_o),
    .wb_valid_i   (wb_valid_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_err_o    (rsp_err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] data);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_data_i  = data;
  endtask

  task automatic setVec(input int idx, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] n,
                        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                        input logic [31:0] w3, input logic [31:0] w4,
                        input logic [31:0] wbData, input logic [31:0] expData);
    vecs[idx].op       = op;
    vecs[idx].addr     = addr;
    vecs[idx].data     = data;
    vecs[idx].nWords   = n;
    vecs[idx].words[0] = w0;
    vecs[idx].words[1] = w1;
    vecs[idx].words[2] = w2;
    vecs[idx].words[3] = w3;
    vecs[idx].words[4] = w4;
    vecs[idx].wbData   = wbData;
    vecs[idx].expData  = expData;
  endtask

  // One complete transaction with ready held high and a writeback 3 cycles after the last word.
  task automatic runVector(input int idx);
    vec_t v;
    bit   isRead;
    v = vecs[idx];
    isRead = (v.op == 2'd0) || (v.op == 2'd2);
    checkOutput($sformatf("v%0d_cmd_ready", idx), {31'b0, cmd_ready_o}, 32'd1);
    applyStimulus(v.op, v.addr, v.data);
    insn_ready_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    for (int w = 0; w < int'(v.nWords); w++) begin
      checkOutput($sformatf("v%0d_valid%0d", idx, w), {31'b0, insn_valid_o}, 32'd1);
      checkOutput($sformatf("v%0d_word%0d", idx, w), insn_o, v.words[w]);
      if (isRead && w == int'(v.nWords) - 1) begin
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        wb_data_i  = 32'hFFFF0000;
      end
      tick();
      wb_valid_i = 1'b0;
    end
    checkOutput($sformatf("v%0d_valid_off", idx), {31'b0, insn_valid_o}, 32'd0);
    if (isRead) begin
      checkOutput($sformatf("v%0d_rsp_early", idx), {31'b0, rsp_valid_o}, 32'd0);
      wb_valid_i = 1'b1;
      wb_rd_i    = 5'd5;
      wb_data_i  = 32'h5555AAAA;
      tick();
      wb_valid_i = 1'b0;
      tick();
      checkOutput($sformatf("v%0d_rsp_wait", idx), {31'b0, rsp_valid_o}, 32'd0);
      wb_valid_i = 1'b1;
      wb_rd_i    = 5'd3;
      wb_data_i  = v.wbData;
      tick();
      wb_valid_i = 1'b0;
    end
    checkOutput($sformatf("v%0d_rsp_valid", idx), {31'b0, rsp_valid_o}, 32'd1);
    checkOutput($sformatf("v%0d_rsp_data", idx), rsp_data_o, v.expData);
    checkOutput($sformatf("v%0d_rsp_err", idx), {31'b0, rsp_err_o}, 32'd0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checkOutput($sformatf("v%0d_rsp_done", idx), {31'b0, rsp_valid_o}, 32'd0);
    checkOutput($sformatf("v%0d_idle_ready", idx), {31'b0, cmd_ready_o}, 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid_i  = 1'b0;
    cmd_op_i     = 2'd0;
    cmd_addr_i   = '0;
    cmd_data_i   = '0;
    insn_ready_i = 1'b0;
    wb_valid_i   = 1'b0;
    wb_rd_i      = '0;
    wb_data_i    = '0;
    rsp_ready_i  = 1'b0;

    setVec(0, 2'd1, 32'h00000011, 32'hDEADBEEF, 3'd5,
           32'h1860DEAD, 32'hA863BEEF, 32'h18800000, 32'hA8840011, 32'hC0041800,
           32'h0, 32'h0);
    setVec(1, 2'd2, 32'h00001000, 32'h77777777, 3'd3,
           32'h18800000, 32'hA8841000, 32'h84640000, 32'h0, 32'h0,
           32'h12345678, 32'h12345678);
    setVec(2, 2'd3, 32'hCAFE0004, 32'h0000FFFF, 3'd5,
           32'h18600000, 32'hA863FFFF, 32'h1880CAFE, 32'hA8840004, 32'hD4041800,
           32'h0, 32'h0);
    setVec(3, 2'd0, 32'hFFFF8001, 32'h77777777, 3'd3,
           32'h1880FFFF, 32'hA8848001, 32'hB4640000, 32'h0, 32'h0,
           32'hA5A5A5A5, 32'hA5A5A5A5);

    tick();
    tick();
    checkOutput("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    checkOutput("rst_insn_valid", {31'b0, insn_valid_o}, 32'd0);
    checkOutput("rst_insn", insn_o, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data_o, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) runVector(i);

    // Fetch stalls for 4 cycles while the second RD_SPR word is on the port.
    applyStimulus(2'd0, 32'h00000011, 32'h0);
    insn_ready_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    checkOutput("stall_w0", insn_o, 32'h18800000);
    tick();
    insn_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("stall_hold%0d", k), insn_o, 32'hA8840011);
      checkOutput($sformatf("stall_valid%0d", k), {31'b0, insn_valid_o}, 32'd1);
      tick();
    end
    insn_ready_i = 1'b1;
    checkOutput("stall_w1", insn_o, 32'hA8840011);
    tick();
    checkOutput("stall_w2", insn_o, 32'hB4640000);
    tick();
    checkOutput("stall_done", {31'b0, insn_valid_o}, 32'd0);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd3;
    wb_data_i  = 32'h0BADF00D;
    tick();
    wb_valid_i = 1'b0;
    checkOutput("stall_rsp_data", rsp_data_o, 32'h0BADF00D);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Only writebacks to r5 arrive; the timeout fires 16 cycles into WAIT_WB.
    applyStimulus(2'd0, 32'h00000020, 32'h0);
    tick();
    cmd_valid_i = 1'b0;
    checkOutput("to_w0", insn_o, 32'h18800000);
    tick();
    checkOutput("to_w1", insn_o, 32'hA8840020);
    tick();
    checkOutput("to_w2", insn_o, 32'hB4640000);
    tick();
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd5;
    wb_data_i  = 32'hCAFEF00D;
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("to_wait%0d", k), {31'b0, rsp_valid_o}, 32'd0);
      tick();
    end
    wb_valid_i = 1'b0;
    checkOutput("to_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    checkOutput("to_rsp_err", {31'b0, rsp_err_o}, 32'd1);
    checkOutput("to_rsp_data", rsp_data_o, 32'd0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Command held valid while busy and the response is back-pressured.
    applyStimulus(2'd1, 32'h00000011, 32'h00000001);
    tick();
    begin
      logic [31:0] bpWords [5];
      bpWords = '{32'h18600000, 32'hA8630001, 32'h18800000, 32'hA8840011, 32'hC0041800};
      for (int w = 0; w < 5; w++) begin
        checkOutput($sformatf("bp_busy%0d", w), {31'b0, cmd_ready_o}, 32'd0);
        checkOutput($sformatf("bp_word%0d", w), insn_o, bpWords[w]);
        tick();
      end
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp_rsp_ready%0d", k), {31'b0, cmd_ready_o}, 32'd0);
      checkOutput($sformatf("bp_rsp_valid%0d", k), {31'b0, rsp_valid_o}, 32'd1);
      checkOutput($sformatf("bp_rsp_data%0d", k), rsp_data_o, 32'd0);
      checkOutput($sformatf("bp_rsp_err%0d", k), {31'b0, rsp_err_o}, 32'd0);
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checkOutput("bp_idle_ready", {31'b0, cmd_ready_o}, 32'd1);
    checkOutput("bp_idle_rsp", {31'b0, rsp_valid_o}, 32'd0);
    applyStimulus(2'd0, 32'h00120022, 32'h0);
    tick();
    cmd_valid_i = 1'b0;
    checkOutput("bp_second_valid", {31'b0, insn_valid_o}, 32'd1);
    checkOutput("bp_second_w0", insn_o, 32'h18800012);
    checkOutput("bp_second_busy", {31'b0, cmd_ready_o}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset lands while WR_MEM is showing step 2; a fresh command restarts at step 0.
    applyStimulus(2'd3, 32'h00000100, 32'h00000055);
    tick();
    cmd_valid_i = 1'b0;
    checkOutput("rm_w0", insn_o, 32'h18600000);
    tick();
    checkOutput("rm_w1", insn_o, 32'hA8630055);
    tick();
    checkOutput("rm_w2", insn_o, 32'h18800000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rm_insn_valid", {31'b0, insn_valid_o}, 32'd0);
    checkOutput("rm_insn", insn_o, 32'd0);
    checkOutput("rm_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    checkOutput("rm_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
    runVector(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
